// File: rtl/useq_stack_if.sv
// Sequencer <-> CPU bus: opcode and status flags in, control word and
// sequencer status out. The stall line exists only when USEQ_STALL_EN is set.
interface useq_stack_if #(
    parameter int OPCODE_W = 7,
    parameter int UADDR_W  = 8,
    parameter int CTRL_W   = 27
);
    logic [OPCODE_W-1:0] opcode;
    logic                statusC;
    logic                statusZ;
`ifdef USEQ_STALL_EN
    logic                stall;
`endif
    logic [CTRL_W-1:0]   control;
    logic [UADDR_W-1:0]  uPC;
    logic                halted;
    logic                stackErr;

    // Sequencer side: drives the control word and its own status.
    modport master (
        input  opcode, statusC, statusZ,
`ifdef USEQ_STALL_EN
        input  stall,
`endif
        output control, uPC, halted, stackErr
    );

    // CPU / datapath side.
    modport slave (
        output opcode, statusC, statusZ,
`ifdef USEQ_STALL_EN
        output stall,
`endif
        input  control, uPC, halted, stackErr
    );
endinterface

// File: rtl/useq_stack.sv
// Microsequencer with an asynchronous-read microcode ROM, C/Z conditional
// branches, opcode dispatch, CALL/RET on a bounded return stack, HALT and
// a sticky stack-error flag.
// Optional macro USEQ_STALL_EN adds a stall input that freezes all state.
// ROM word layout, MSB..LSB: ctrl[CTRL_W], op[3], target[UADDR_W].
// The ROM image is supplied as the packed parameter ROM_INIT (word i at
// bits [i*ROM_W +: ROM_W]); ROM_FILENAME names the source image it was
// generated from and is not read by the hardware.
module useq_stack #(
    parameter int OPCODE_W    = 7,
    parameter int UADDR_W     = 8,
    parameter int CTRL_W      = 27,
    parameter int STACK_DEPTH = 4,
    parameter     ROM_FILENAME = "urom.lst",
    parameter logic [(2**UADDR_W)*(CTRL_W+3+UADDR_W)-1:0] ROM_INIT = '0
) (
    input  logic          clock,
    input  logic          notReset,
    useq_stack_if.master  bus
);
    localparam int ROM_W = CTRL_W + 3 + UADDR_W;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000, OP_JMP  = 3'b001, OP_JC   = 3'b010, OP_JZ   = 3'b011,
        OP_DISP = 3'b100, OP_CALL = 3'b101, OP_RET  = 3'b110, OP_HALT = 3'b111
    } op_t;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t              state, state_n;
    logic [UADDR_W-1:0]  upc, upc_n, upc_inc, tgt;
    logic [SP_W-1:0]     sp, sp_n;
    logic                err, err_n;
    logic                push;
    logic                stall;
    logic [ROM_W-1:0]    word;
    op_t                 op;
    logic [UADDR_W-1:0]  stack [2**IDX_W];
    logic [IDX_W-1:0]    push_idx, pop_idx;
    logic                unused_rom_name;

    assign unused_rom_name = ^ROM_FILENAME;

`ifdef USEQ_STALL_EN
    assign stall = bus.stall;
`else
    assign stall = 1'b0;
`endif

    // Asynchronous ROM read and field split.
    assign word    = ROM_INIT[upc*ROM_W +: ROM_W];
    assign op      = op_t'(word[UADDR_W +: 3]);
    assign tgt     = word[UADDR_W-1:0];
    assign upc_inc = upc + 1'b1;   // wraps modulo 2**UADDR_W

    assign push_idx = IDX_W'(sp);
    assign pop_idx  = IDX_W'(sp - 1'b1);

    assign bus.control  = word[ROM_W-1 -: CTRL_W];
    assign bus.uPC      = upc;
    assign bus.halted   = (state == S_HALT);
    assign bus.stackErr = err;

    // State register: uPC, stack pointer, sticky error, run/halt.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state <= S_RUN;
            upc   <= '0;
            sp    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            upc   <= upc_n;
            sp    <= sp_n;
            err   <= err_n;
        end
    end

    // Return-stack storage; contents are not reset, sp alone marks validity.
    always_ff @(posedge clock) begin
        if (push) stack[push_idx] <= upc_inc;
    end

    // Next-state decode from the current op; errors halt with uPC held.
    always_comb begin
        state_n = state;
        upc_n   = upc;
        sp_n    = sp;
        err_n   = err;
        push    = 1'b0;
        if (state == S_RUN && !stall) begin
            case (op)
                OP_SEQ:  upc_n = upc_inc;
                OP_JMP:  upc_n = tgt;
                OP_JC:   upc_n = bus.statusC ? tgt : upc_inc;
                OP_JZ:   upc_n = bus.statusZ ? tgt : upc_inc;
                OP_DISP: upc_n = UADDR_W'(bus.opcode);
                OP_CALL: begin
                    if (sp == SP_W'(STACK_DEPTH)) begin
                        err_n   = 1'b1;
                        state_n = S_HALT;
                    end else begin
                        push  = 1'b1;
                        sp_n  = sp + 1'b1;
                        upc_n = tgt;
                    end
                end
                OP_RET: begin
                    if (sp == '0) begin
                        err_n   = 1'b1;
                        state_n = S_HALT;
                    end else begin
                        upc_n = stack[pop_idx];
                        sp_n  = sp - 1'b1;
                    end
                end
                OP_HALT: state_n = S_HALT;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_useq_stack.sv
// Directed bench for useq_stack. One ROM image holds every test routine;
// each routine is reached by reset, then 0 SEQ -> 1 JC -> 2 JZ -> 3 DISPATCH
// with C=Z=0 and the routine address on opcode.
module tb_useq_stack;
    localparam int OW = 7;
    localparam int AW = 8;
    localparam int CW = 27;
    localparam int RW = CW + 3 + AW;

    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, JC = 3'd2, JZ = 3'd3;
    localparam logic [2:0] DSP = 3'd4, CALL = 3'd5, RET = 3'd6, HLT = 3'd7;

    // Non-reset words carry ctrl = 27'h1000000 | address.
    function automatic logic [RW-1:0] w(int a, logic [2:0] op, int t);
        logic [CW-1:0] c;
        logic [AW-1:0] ta;
        c  = 27'h1000000 | CW'(a);
        ta = AW'(t);
        return {c, op, ta};
    endfunction

    function automatic logic [256*RW-1:0] build_rom();
        logic [256*RW-1:0] r;
        r = '0;
        r[0*RW +: RW]    = {27'h5A5A5A5, SEQ, 8'd0};
        r[1*RW +: RW]    = w(1, JC, 40);
        r[2*RW +: RW]    = w(2, JZ, 60);
        r[3*RW +: RW]    = w(3, DSP, 0);
        // nested calls 10 -> 20 -> 30 -> 40 -> 50, returns 41, 31, 21, 11
        r[10*RW +: RW]   = w(10, CALL, 20);
        r[11*RW +: RW]   = w(11, HLT, 0);
        r[20*RW +: RW]   = w(20, CALL, 30);
        r[21*RW +: RW]   = w(21, RET, 0);
        r[30*RW +: RW]   = w(30, CALL, 40);
        r[31*RW +: RW]   = w(31, RET, 0);
        r[40*RW +: RW]   = w(40, CALL, 50);
        r[41*RW +: RW]   = w(41, RET, 0);
        r[50*RW +: RW]   = w(50, RET, 0);
        r[18*RW +: RW]   = w(18, JMP, 254);
        r[254*RW +: RW]  = w(254, SEQ, 0);
        r[255*RW +: RW]  = w(255, SEQ, 0);
        r[60*RW +: RW]   = w(60, HLT, 0);
        // overflow chain: five nested calls, the fifth at 110
        r[70*RW +: RW]   = w(70, CALL, 80);
        r[80*RW +: RW]   = w(80, CALL, 90);
        r[90*RW +: RW]   = w(90, CALL, 105);
        r[105*RW +: RW]  = w(105, CALL, 110);
        r[110*RW +: RW]  = w(110, CALL, 120);
        r[100*RW +: RW]  = w(100, RET, 0);
        r[127*RW +: RW]  = w(127, HLT, 0);
        return r;
    endfunction

    localparam logic [256*RW-1:0] ROM_IMG = build_rom();

    logic clock = 1'b0;
    logic notReset = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    always #5 clock = ~clock;

    useq_stack_if #(.OPCODE_W(OW), .UADDR_W(AW), .CTRL_W(CW)) bus ();

    useq_stack #(
        .OPCODE_W(OW), .UADDR_W(AW), .CTRL_W(CW), .STACK_DEPTH(4),
        .ROM_FILENAME("urom.lst"), .ROM_INIT(ROM_IMG)
    ) dut (
        .clock(clock),
        .notReset(notReset),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Assert reset mid-cycle, check the immediate effect, hold 3 clocks.
    task automatic do_reset();
        notReset = 1'b0;
        #1;
        chk("rst_upc", 32'(bus.uPC), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_err", 32'(bus.stackErr), 32'd0);
        repeat (3) tick();
        chk("rst_ctrl", 32'(bus.control), 32'h5A5A5A5);
        notReset = 1'b1;
    endtask

    task automatic goto(input int a);
        do_reset();
        bus.statusC = 1'b0;
        bus.statusZ = 1'b0;
        bus.opcode  = OW'(a);
        repeat (4) tick();
        chk("goto_upc", 32'(bus.uPC), 32'(a));
    endtask

    initial begin
        bus.opcode  = '0;
        bus.statusC = 1'b0;
        bus.statusZ = 1'b0;
`ifdef USEQ_STALL_EN
        bus.stall   = 1'b0;
`endif
        // reset and first fetch
        do_reset();
        tick();
        chk("first_edge", 32'(bus.uPC), 32'd1);
        tick();
        chk("jc_not_taken", 32'(bus.uPC), 32'd2);
        bus.statusZ = 1'b1;
        tick();
        chk("jz_taken", 32'(bus.uPC), 32'd60);
        tick();
        chk("halt60_halted", 32'(bus.halted), 32'd1);
        chk("halt60_upc", 32'(bus.uPC), 32'd60);

        // JC taken
        do_reset();
        bus.statusC = 1'b1;
        bus.statusZ = 1'b0;
        tick();
        tick();
        chk("jc_taken", 32'(bus.uPC), 32'd40);
        chk("ctrl_40", 32'(bus.control), 32'h1000028);

        // dispatch then wrap at 0xFF
        goto(8'h12);
        chk("ctrl_12", 32'(bus.control), 32'h1000012);
        tick();
        chk("jmp_fe", 32'(bus.uPC), 32'hFE);
        tick();
        chk("seq_ff", 32'(bus.uPC), 32'hFF);
        tick();
        chk("wrap_00", 32'(bus.uPC), 32'h00);
        chk("wrap_ctrl", 32'(bus.control), 32'h5A5A5A5);

        // nested calls and returns
        goto(10);
`ifdef USEQ_STALL_EN
        bus.stall = 1'b1;
        repeat (5) tick();
        chk("stall_upc", 32'(bus.uPC), 32'd10);
        bus.stall = 1'b0;
`endif
        tick(); chk("call_20", 32'(bus.uPC), 32'd20);
        tick(); chk("call_30", 32'(bus.uPC), 32'd30);
        tick(); chk("call_40", 32'(bus.uPC), 32'd40);
        tick(); chk("call_50", 32'(bus.uPC), 32'd50);
        tick(); chk("ret_41", 32'(bus.uPC), 32'd41);
        tick(); chk("ret_31", 32'(bus.uPC), 32'd31);
        tick(); chk("ret_21", 32'(bus.uPC), 32'd21);
        tick(); chk("ret_11", 32'(bus.uPC), 32'd11);
        chk("nest_err", 32'(bus.stackErr), 32'd0);
        tick();
        chk("nest_halt", 32'(bus.halted), 32'd1);
        chk("nest_halt_err", 32'(bus.stackErr), 32'd0);

        // overflow: fifth call at 110
        goto(70);
        repeat (4) tick();
        chk("ovf_pre", 32'(bus.uPC), 32'd110);
        tick();
        chk("ovf_upc", 32'(bus.uPC), 32'd110);
        chk("ovf_err", 32'(bus.stackErr), 32'd1);
        chk("ovf_halted", 32'(bus.halted), 32'd1);
        repeat (3) tick();
        chk("ovf_hold", 32'(bus.uPC), 32'd110);

        // underflow: RET with empty stack
        goto(100);
        tick();
        chk("unf_upc", 32'(bus.uPC), 32'd100);
        chk("unf_err", 32'(bus.stackErr), 32'd1);
        chk("unf_halted", 32'(bus.halted), 32'd1);

        // HALT op at 0x7F, frozen for 10 clocks, then reset mid-HALT
        goto(8'h7F);
        tick();
        chk("hlt_halted", 32'(bus.halted), 32'd1);
        chk("hlt_err", 32'(bus.stackErr), 32'd0);
        repeat (10) tick();
        chk("hlt_upc", 32'(bus.uPC), 32'h7F);
        chk("hlt_still", 32'(bus.halted), 32'd1);
        chk("hlt_ctrl", 32'(bus.control), 32'h100007F);
        #2;
        do_reset();
        tick();
        chk("post_rst", 32'(bus.uPC), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/useq_stack.md
Name: useq_stack

Overview:
- Parametrised successor to the fixed-width CPU microsequencer.
- Holds a micro-PC (uPC) and an asynchronous-read microcode ROM, and drives the CPU control word from it each microcycle.
- Additions over the existing sequencer: configurable opcode, uPC and control widths; conditional branches on the C and Z flags; micro-subroutine CALL/RET with a bounded return stack; a HALT state and sticky stack-error detection.

Parameters:
- OPCODE_W, 7, instruction-register opcode width.
- UADDR_W, 8, uPC width; ROM depth is 2**UADDR_W; must be >= OPCODE_W.
- CTRL_W, 27, control word width driven to the datapath.
- STACK_DEPTH, 4, return-stack entries; range 1..16.
- ROM_FILENAME, "urom.lst", $readmemb image, word width CTRL_W+3+UADDR_W.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- notReset  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  opcode from the instruction register.
- statusC  in  1  carry flag from the status register.
- statusZ  in  1  zero flag from the status register.
- control  out  CTRL_W  control word, ROM[uPC][CTRL_W+3+UADDR_W-1 : 3+UADDR_W].
- uPC  out  UADDR_W  current micro-address.
- halted  out  1  sequencer is in HALT.
- stackErr  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset is asynchronous, active-low (notReset=0). While asserted:
  - uPC=0, stack pointer sp=0, halted=0, stackErr=0.
  - control = ctrl field of ROM[0].
- Reset takes effect mid-instruction or mid-subroutine; the stack contents are discarded.
- ROM word layout, MSB..LSB: ctrl[CTRL_W], op[3], target[UADDR_W].
- control is combinational from uPC: zero latency after uPC changes.
- Next uPC is computed from the op of the current word, with C and Z sampled at the same rising edge:
  - 000 SEQ: uPC+1.
  - 001 JMP: target.
  - 010 JC: target if statusC=1, else uPC+1.
  - 011 JZ: target if statusZ=1, else uPC+1.
  - 100 DISPATCH: opcode zero-extended to UADDR_W.
  - 101 CALL: push uPC+1, uPC=target.
  - 110 RET: pop the top of stack into uPC.
  - 111 HALT: uPC unchanged, halted=1.
- uPC+1 wraps modulo 2**UADDR_W (the last address goes to 0). This also applies to the address pushed by CALL.
- Return stack is LIFO; sp counts valid entries, 0..STACK_DEPTH.
  - CALL with sp==STACK_DEPTH is overflow: no push, no jump, stackErr=1, halted=1, uPC held.
  - RET with sp==0 is underflow: uPC held, stackErr=1, halted=1.
- HALT state:
  - Once halted=1, uPC, sp and stack are frozen.
  - Only notReset leaves it.
  - control keeps showing the word at the held uPC.
- stackErr clears only on reset.
- Reaching HALT via op 111 never sets stackErr.
- No simultaneous push and pop: one op per cycle.

Optional Feature:
- Macro USEQ_STALL_EN.
- When defined:
  - Extra input port stall (1 bit), placed after statusZ.
  - While stall=1 at a rising edge, uPC, sp, stack, halted and stackErr hold, and no errors are detected.
  - control continues to reflect the current uPC.
  - Reset overrides stall.
- When not defined: no port; the sequencer advances every cycle.

Test Plan:
- Reset: hold notReset=0 for 3 clocks, with ROM[0] ctrl=27'h5A5A5A5 and op=SEQ.
  - During reset: uPC=0, control=27'h5A5A5A5, halted=0, stackErr=0.
  - After release: uPC=1 on the first edge.
- Branches:
  - ROM[1]=JC target 8d40 with statusC=0 -> uPC=2.
  - Repeat with statusC=1 -> uPC=40.
  - ROM[2]=JZ target 8d60 with statusZ=1 -> uPC=60.
- Dispatch: opcode=7'h12 at a DISPATCH word -> next uPC=8'h12. Then a SEQ chain at 8'hFF -> wraps to 8'h00.
- Nested calls: STACK_DEPTH=4, four nested CALLs from uPC 10,20,30,40.
  - Four RETs return to 11,21,31,41 in reverse order; stackErr=0.
  - A fifth CALL instead -> stackErr=1, halted=1, uPC stays 50.
- Underflow and HALT:
  - RET with sp=0 -> stackErr=1, halted=1.
  - HALT op at uPC 7F -> halted=1, stackErr=0, uPC stays 7F for 10 clocks.
  - Asserting notReset=0 mid-HALT -> immediate uPC=0, halted=0.
- USEQ_STALL_EN: stall=1 for 5 clocks during a CALL word -> uPC and sp unchanged; on stall=0, the call is taken on the next edge.
